tim_arbiter: RTL and testbench
==============================

TIM_ARBITER -- requirements
Module: tim_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths come from the shared configure package.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 i_valid / d_valid  input  1  one-cycle request pulse from the instruction / data port.
REQ-006 i_addr / d_addr  input  32  byte address; bits [1:0] are ignored.
REQ-007 i_wdata / d_wdata  input  32  write data.
REQ-008 i_wstrb / d_wstrb  input  4  byte strobes; 0 means read.
REQ-009 i_rdata / d_rdata  output  32  read data, valid when the matching ready is 1.
REQ-010 i_ready / d_ready  output  1  one-cycle completion pulse per accepted request.
REQ-011 tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb  output  1/1/32/32/4  shared TIM request.
REQ-012 tim_rdata, tim_ready  input  32/1  TIM response, one cycle after tim_valid.
REQ-013 ovf  output  1  sticky overflow flag: a request was dropped.

Function
REQ-014 The block SHALL hold one pending slot per port (valid, addr, wdata, wstrb).
REQ-015 Candidate per port: the pending slot if it is valid, otherwise the live request.
REQ-016 A pending candidate SHALL beat a live candidate.
REQ-017 Two live candidates SHALL be resolved by the tie rule in REQ-031/REQ-032.
REQ-018 The grant SHALL drive tim_* combinationally in the same cycle.
- tim_instr = 1 for an instruction-port grant.
- At most one grant per cycle.
REQ-019 A losing live request SHALL be captured into its port's pending slot at the clock edge.
- A granted pending slot is cleared at the same edge.
REQ-020 At most one pending slot SHALL be valid at any time; this is an invariant the bench asserts.
REQ-021 An owner register SHALL record the granted port and a valid bit.
- Response routing: x_ready = tim_ready & owner_valid & (owner == x).
- x_rdata = tim_rdata when x_ready is 1, else 0.
REQ-022 Latency: an uncontested request sees ready 1 cycle after valid; a contested loser sees ready 2 cycles after valid.
REQ-023 A port SHALL NOT issue a new valid before its previous ready; issuing in the cycle ready is asserted is permitted.
REQ-024 If a live valid arrives while that port's own pending slot is valid:
- the request SHALL be dropped;
- ovf SHALL set and stay set until reset.
REQ-025 A tim_ready received with owner_valid = 0 SHALL be ignored; no port ready is asserted.

Reset
REQ-026 While reset = 1, the block SHALL asynchronously clear pending slots, owner_valid, the round-robin pointer and ovf.
REQ-027 While reset = 1, all outputs SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard pending and in-flight requests; no ready is produced for them.
REQ-029 In the first cycle after reset deassertion, the block SHALL grant a live request normally.

Configuration
REQ-030 The macro TIM_ARB_RR_EN SHALL select the live-vs-live tie rule.
REQ-031 With TIM_ARB_RR_EN defined:
- a 1-bit pointer names the preferred port and wins ties;
- after any grant, the pointer SHALL point to the other port;
- reset value: data port.
REQ-032 With TIM_ARB_RR_EN undefined: the data port SHALL always win ties, and no pointer is instantiated.

Structure
REQ-033 A package tim_arb_wires SHALL hold:
- the port request struct (valid, instr, addr, wdata, wstrb);
- the owner encoding constants OWN_INSTR = 0, OWN_DATA = 1;
- the zero init constant.
REQ-034 One sub-module, tim_arb_slot (pending register with capture/clear), SHALL be instantiated once per port.

Verification
REQ-035 Single data read: d_valid with addr 0x40, wstrb 0 at cycle 0; TIM returns 0xDEADBEEF.
- Expect d_ready = 1 and d_rdata = 0xDEADBEEF at cycle 1.
- Expect i_ready = 0 throughout.
REQ-036 Collision, TIM_ARB_RR_EN undefined: i_valid and d_valid together at cycle 0.
- Expect tim_instr = 0 at cycle 0 and tim_instr = 1 at cycle 1.
- Expect d_ready at cycle 1 and i_ready at cycle 2.
REQ-037 Collision, TIM_ARB_RR_EN defined: the pointer is at the instruction port after a prior data grant; both ports request.
- Expect the instruction port granted first.
- Expect the pointer to toggle to the data port.
REQ-038 Pending beats live: a collision at cycle 0 leaves the instruction request pending; a new d_valid arrives at cycle 1.
- Expect the instruction grant at cycle 1 and the data request captured as pending.
- Expect the data grant at cycle 2 and d_ready at cycle 3.
REQ-039 Overflow and reset:
- Force a protocol violation (second i_valid while its slot is pending); expect ovf = 1 and only one i_ready.
- Assert reset during an in-flight request; expect all outputs 0 and no ready after release.

Source files
------------

// File: rtl/tim_arb_wires.sv
// ============================================================================
// Module      : tim_arb_wires (package)
// Description : Shared widths, request struct and owner encoding for the
//               two-port TIM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tim_arb_wires;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic              valid;
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } tim_req_t;

    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam tim_req_t REQ_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/tim_arb_slot.sv
// ============================================================================
// Module      : tim_arb_slot
// Description : One-entry pending register; capture has priority over clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tim_arb_slot
    import tim_arb_wires::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     i_capture,
    input  logic     i_clear,
    input  tim_req_t i_req,
    output tim_req_t o_req
);

    tim_req_t r_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req <= REQ_ZERO;
        end else if (i_capture) begin
            r_req <= i_req;
        end else if (i_clear) begin
            r_req <= REQ_ZERO;
        end
    end

    assign o_req = r_req;

endmodule

`default_nettype wire

// File: rtl/tim_arbiter.sv
// ============================================================================
// Module      : tim_arbiter
// Description : Arbitrates instruction and data ports onto one TIM port.
//               Macro TIM_ARB_RR_EN selects round-robin tie breaking
//               (default: data port always wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tim_arbiter
    import tim_arb_wires::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              tim_valid,
    output logic              tim_instr,
    output logic [ADDR_W-1:0] tim_addr,
    output logic [DATA_W-1:0] tim_wdata,
    output logic [STRB_W-1:0] tim_wstrb,
    input  logic [DATA_W-1:0] tim_rdata,
    input  logic              tim_ready,
    output logic              ovf
);

    tim_req_t w_i_live, w_d_live;
    tim_req_t w_i_pend, w_d_pend;
    tim_req_t w_i_cand, w_d_cand;
    tim_req_t w_gnt;
    logic     w_tie_port;
    logic     w_gnt_port;
    logic     w_gnt_valid;
    logic     w_i_cap, w_d_cap;
    logic     w_i_clr, w_d_clr;
    logic     w_i_drop, w_d_drop;
    logic     r_own_valid;
    logic     r_owner;
    logic     r_ovf;

    assign w_i_live = '{valid: i_valid, instr: 1'b1, addr: i_addr, wdata: i_wdata, wstrb: i_wstrb};
    assign w_d_live = '{valid: d_valid, instr: 1'b0, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};

    assign w_i_cand = w_i_pend.valid ? w_i_pend : w_i_live;
    assign w_d_cand = w_d_pend.valid ? w_d_pend : w_d_live;

`ifdef TIM_ARB_RR_EN
    logic r_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= OWN_DATA;
        end else if (w_gnt_valid) begin
            r_ptr <= ~w_gnt_port;
        end
    end

    assign w_tie_port = r_ptr;
`else
    assign w_tie_port = OWN_DATA;
`endif

    // Pending slots outrank live requests; only one slot can ever be valid.
    always_comb begin
        w_gnt_port = OWN_DATA;
        if (w_i_pend.valid) begin
            w_gnt_port = OWN_INSTR;
        end else if (w_d_pend.valid) begin
            w_gnt_port = OWN_DATA;
        end else if (i_valid && d_valid) begin
            w_gnt_port = w_tie_port;
        end else if (i_valid) begin
            w_gnt_port = OWN_INSTR;
        end
    end

    assign w_gnt       = (w_gnt_port == OWN_INSTR) ? w_i_cand : w_d_cand;
    assign w_gnt_valid = ~reset & w_gnt.valid;

    assign tim_valid = w_gnt_valid;
    assign tim_instr = w_gnt_valid & w_gnt.instr;
    assign tim_addr  = w_gnt_valid ? w_gnt.addr  : '0;
    assign tim_wdata = w_gnt_valid ? w_gnt.wdata : '0;
    assign tim_wstrb = w_gnt_valid ? w_gnt.wstrb : '0;

    // A live request colliding with its own pending slot is dropped, not queued.
    assign w_i_drop = i_valid & w_i_pend.valid;
    assign w_d_drop = d_valid & w_d_pend.valid;
    assign w_i_cap  = i_valid & ~w_i_pend.valid & ~(w_gnt_valid & (w_gnt_port == OWN_INSTR));
    assign w_d_cap  = d_valid & ~w_d_pend.valid & ~(w_gnt_valid & (w_gnt_port == OWN_DATA));
    assign w_i_clr  = w_i_pend.valid & w_gnt_valid & (w_gnt_port == OWN_INSTR);
    assign w_d_clr  = w_d_pend.valid & w_gnt_valid & (w_gnt_port == OWN_DATA);

    tim_arb_slot u_slot_i (
        .clock     (clock),
        .reset     (reset),
        .i_capture (w_i_cap),
        .i_clear   (w_i_clr),
        .i_req     (w_i_live),
        .o_req     (w_i_pend)
    );

    tim_arb_slot u_slot_d (
        .clock     (clock),
        .reset     (reset),
        .i_capture (w_d_cap),
        .i_clear   (w_d_clr),
        .i_req     (w_d_live),
        .o_req     (w_d_pend)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_own_valid <= 1'b0;
            r_owner     <= OWN_INSTR;
            r_ovf       <= 1'b0;
        end else begin
            r_own_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_owner <= w_gnt_port;
            end
            r_ovf <= r_ovf | w_i_drop | w_d_drop;
        end
    end

    assign i_ready = tim_ready & r_own_valid & (r_owner == OWN_INSTR);
    assign d_ready = tim_ready & r_own_valid & (r_owner == OWN_DATA);
    assign i_rdata = i_ready ? tim_rdata : '0;
    assign d_rdata = d_ready ? tim_rdata : '0;
    assign ovf     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_tim_arbiter.sv
// ============================================================================
// Module      : tb_tim_arbiter
// Description : Directed scoreboard bench for tim_arbiter; TIM responder
//               returns addr ^ 0xDEADBEAF one cycle after each grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tim_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, i_wdata = '0, d_wdata = '0;
    logic [3:0]  i_wstrb = '0, d_wstrb = '0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready;
    logic        tim_valid, tim_instr;
    logic [31:0] tim_addr, tim_wdata;
    logic [3:0]  tim_wstrb;
    logic [31:0] tim_rdata = '0;
    logic        tim_ready = 1'b0;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int c      = 0;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q_i[$];
    exp_t q_d[$];

    tim_arbiter dut (
        .clock     (clk),
        .reset     (rst),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .tim_valid (tim_valid),
        .tim_instr (tim_instr),
        .tim_addr  (tim_addr),
        .tim_wdata (tim_wdata),
        .tim_wstrb (tim_wstrb),
        .tim_rdata (tim_rdata),
        .tim_ready (tim_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TIM responder
    always @(posedge clk) begin
        tim_ready <= tim_valid;
        tim_rdata <= tim_valid ? (tim_addr ^ 32'hDEADBEAF) : 32'h0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_i(input logic [31:0] rd, input int cy);
        exp_t e;
        e.rdata = rd;
        e.cyc   = cy;
        q_i.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] rd, input int cy);
        exp_t e;
        e.rdata = rd;
        e.cyc   = cy;
        q_d.push_back(e);
    endtask

    // Drive one cycle of requests, check the TIM side mid-cycle, advance.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [3:0] is,
                        input logic dv, input logic [31:0] da, input logic [3:0] ds,
                        input logic etv, input logic eti, input logic [31:0] eta,
                        input logic [3:0] ews, input string nm);
        i_valid = iv; i_addr = ia; i_wdata = ~ia; i_wstrb = is;
        d_valid = dv; d_addr = da; d_wdata = ~da; d_wstrb = ds;
        @(negedge clk);
        check({nm, "_tim_valid"}, {31'b0, tim_valid}, {31'b0, etv});
        if (etv) begin
            check({nm, "_tim_instr"}, {31'b0, tim_instr}, {31'b0, eti});
            check({nm, "_tim_addr"}, tim_addr, eta);
            check({nm, "_tim_wdata"}, tim_wdata, ~eta);
            check({nm, "_tim_wstrb"}, {28'b0, tim_wstrb}, {28'b0, ews});
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic idle(input string nm);
        step(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, nm);
    endtask

    // Monitor: pops the scoreboard whenever a port presents ready
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("pend_invariant",
                  {31'b0, dut.w_i_pend.valid & dut.w_d_pend.valid}, 32'h0);
        end
        if (i_ready) begin
            if (q_i.size() == 0) begin
                check("i_ready_unexpected", {31'b0, i_ready}, 32'h0);
            end else begin
                e = q_i.pop_front();
                check("i_rdata", i_rdata, e.rdata);
                check("i_ready_cycle", cyc, e.cyc);
            end
        end
        if (d_ready) begin
            if (q_d.size() == 0) begin
                check("d_ready_unexpected", {31'b0, d_ready}, 32'h0);
            end else begin
                e = q_d.pop_front();
                check("d_rdata", d_rdata, e.rdata);
                check("d_ready_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        // Outputs held at zero during reset even with live requests
        repeat (2) @(posedge clk);
        #1;
        i_valid = 1'b1; i_addr = 32'h10;
        d_valid = 1'b1; d_addr = 32'h20;
        @(negedge clk);
        check("rst_tim_valid", {31'b0, tim_valid}, 32'h0);
        check("rst_tim_instr", {31'b0, tim_instr}, 32'h0);
        check("rst_tim_addr", tim_addr, 32'h0);
        check("rst_readys", {30'b0, i_ready, d_ready}, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'h0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        rst     = 1'b0;

        // Single data read, first cycle after reset release
        c = cyc;
        push_d(32'hDEADBEEF, c + 1);
        step(0, 32'h0, 4'h0, 1, 32'h40, 4'h0, 1, 0, 32'h40, 4'h0, "t1_c0");
        idle("t1_c1");

        // Collision: tie rule decides the first grant
        c = cyc;
`ifdef TIM_ARB_RR_EN
        push_i(32'hDEADBFAF, c + 1);
        push_d(32'hDEADBCAF, c + 2);
        step(1, 32'h100, 4'h0, 1, 32'h200, 4'h3, 1, 1, 32'h100, 4'h0, "t2_c0");
        check("t2_ptr", {31'b0, dut.r_ptr}, 32'h1);
        step(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 32'h200, 4'h3, "t2_c1");
`else
        push_d(32'hDEADBCAF, c + 1);
        push_i(32'hDEADBFAF, c + 2);
        step(1, 32'h100, 4'h0, 1, 32'h200, 4'h3, 1, 0, 32'h200, 4'h3, "t2_c0");
        step(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 1, 32'h100, 4'h0, "t2_c1");
`endif
        idle("t2_c2");

        // Single instruction write
        c = cyc;
        push_i(32'hDEADB8AF, c + 1);
        step(1, 32'h600, 4'hF, 0, 32'h0, 4'h0, 1, 1, 32'h600, 4'hF, "t3a_c0");
        idle("t3a_c1");

        // Pending instruction beats a new live data request
        c = cyc;
        push_d(32'hDEADBAAF, c + 1);
        push_i(32'hDEADBDAF, c + 2);
        push_d(32'hDEADBBAF, c + 3);
        step(1, 32'h300, 4'h0, 1, 32'h400, 4'h1, 1, 0, 32'h400, 4'h1, "t3_c0");
        step(0, 32'h0,   4'h0, 1, 32'h500, 4'hC, 1, 1, 32'h300, 4'h0, "t3_c1");
        step(0, 32'h0,   4'h0, 0, 32'h0,   4'h0, 1, 0, 32'h500, 4'hC, "t3_c2");
        idle("t3_c3");

        // Re-aim the pointer (if present) at the data port
        c = cyc;
        push_i(32'hDEADB9AF, c + 1);
        step(1, 32'h700, 4'h0, 0, 32'h0, 4'h0, 1, 1, 32'h700, 4'h0, "t4a_c0");
        idle("t4a_c1");

        // Overflow: second i_valid while the instruction slot is pending
        c = cyc;
        push_d(32'hDEADB7AF, c + 1);
        push_i(32'hDEADB6AF, c + 2);
        step(1, 32'h800, 4'h0, 1, 32'h900, 4'h0, 1, 0, 32'h900, 4'h0, "t4_c0");
        check("ovf_before_drop", {31'b0, ovf}, 32'h0);
        step(1, 32'hA00, 4'h0, 0, 32'h0, 4'h0, 1, 1, 32'h800, 4'h0, "t4_c1");
        check("ovf_set", {31'b0, ovf}, 32'h1);
        idle("t4_c2");
        idle("t4_c3");
        check("ovf_sticky", {31'b0, ovf}, 32'h1);

        // Reset during an in-flight grant with a pending loser
        step(1, 32'hC00, 4'h0, 1, 32'hB00, 4'h0, 1, 0, 32'hB00, 4'h0, "t5_c0");
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tim_valid", {31'b0, tim_valid}, 32'h0);
        check("t5_rst_readys", {30'b0, i_ready, d_ready}, 32'h0);
        check("t5_rst_rdata", i_rdata | d_rdata, 32'h0);
        check("t5_rst_ovf", {31'b0, ovf}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("t5_post0");
        idle("t5_post1");
        idle("t5_post2");

        check("q_i_empty", q_i.size(), 32'h0);
        check("q_d_empty", q_d.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
